m2vblksched: RTL and testbench
==============================

# m2vblksched

Block scheduler for the MPEG2 video decoder's per-block side-information pipeline. It accepts one macroblock descriptor at a time from the VLD side, expands it into six 4:2:0 block issues (blocks 0–5), and drives the stage-1 side-info fields plus the `block_start` pulse that advances the stage-2 side-info container. Issue is throttled by a credit count of blocks still outstanding in the IDCT/MC back end. A picture-end request drains all outstanding blocks before `pic_done` is reported.

## Interface
Parameters:
- MBX_WIDTH, 6, macroblock X address width
- MBY_WIDTH, 5, macroblock Y address width
- MAX_OUTSTANDING, 1, maximum blocks issued but not yet retired; legal range 1..3

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- mb_valid  in  1  macroblock descriptor valid
- mb_ready  out  1  scheduler can accept a descriptor
- mb_cbp  in  6  coded_block_pattern; bit 5 = block 0 … bit 0 = block 5
- mb_intra  in  1  macroblock is intra
- mb_x  in  MBX_WIDTH  macroblock X address
- mb_y  in  MBY_WIDTH  macroblock Y address
- pic_end  in  1  one-cycle pulse: no more macroblocks in this picture
- blk_done  in  1  one-cycle pulse from back end: one block retired
- block_start  out  1  one-cycle pulse: s1_* valid; downstream latches
- s1_block  out  3  block index 0..5
- s1_coded  out  1  block carries coefficients
- s1_mb_intra  out  1  intra flag of current block's macroblock
- s1_mb_x  out  MBX_WIDTH  X address of current block
- s1_mb_y  out  MBY_WIDTH  Y address of current block
- s1_enable  out  1  s1_* describe a real block
- pic_done  out  1  one-cycle pulse: picture fully drained
- err  out  1  sticky protocol error

## Operation
- States:
  - IDLE: mb_ready=1.
  - RUN: issuing the six blocks of a latched macroblock.
  - DRAIN: waiting for outstanding==0 after pic_end.
- IDLE:
  - mb_valid=1 latches cbp, intra, x and y, clears blk_cnt to 0, and moves to RUN.
  - Otherwise, if pic_end or pic_pend is set, moves to DRAIN.
- pic_end arriving in RUN or DRAIN, or in the same cycle as an accept, sets pic_pend. pic_pend clears on entering DRAIN.
- RUN: when outstanding < MAX_OUTSTANDING, registers an issue:
  - block_start=1, s1_block=blk_cnt, s1_enable=1.
  - s1_coded = intra | cbp[5−blk_cnt].
  - s1_mb_intra, s1_mb_x and s1_mb_y take the latched values.
  - outstanding increments and blk_cnt increments.
  - The issue of blk_cnt==5 returns the state to IDLE.
- Non-coded blocks are still issued with s1_coded=0, because MC needs them.
- outstanding counter:
  - +1 on issue, −1 on blk_done.
  - Both in the same cycle: unchanged.
  - Credit check uses the pre-update value.
- blk_done with outstanding==0 and no issue in the same cycle: ignored and sets err. err clears only on reset.
- DRAIN: when outstanding==0, pulses pic_done for one cycle, clears s1_enable, and returns to IDLE. mb_ready=0 throughout DRAIN.
- s1_* hold their values between block_start pulses.
- Reset mid-operation aborts the macroblock and clears all state, including pic_pend.

## Timing
- Reset values:
  - mb_ready=1; all other outputs 0 (block_start, s1_block, s1_coded, s1_mb_intra, s1_mb_x, s1_mb_y, s1_enable, pic_done, err).
  - State IDLE; outstanding=0.
- mb_ready is decoded from the state only.
- All other outputs are registered.
- Accept in cycle C: RUN in C+1; first block_start in C+2 if credit is available.
- With MAX_OUTSTANDING≥2 and credit available, block_start may assert on consecutive cycles.
- MAX_OUTSTANDING=1: blk_done in cycle D gives the next block_start in D+2.
- A 6th issue in cycle I gives mb_ready=1 in I+1. The next macroblock may be accepted while its predecessor's blocks are still outstanding.
- DRAIN with the last blk_done in cycle D: pic_done in D+2.
- pic_done and block_start are never high together.

## Test plan
- Reset:
  - Stimulus: release reset_n, idle inputs.
  - Response: mb_ready=1, all other outputs 0, no block_start for 20 cycles.
- Intra macroblock, MAX_OUTSTANDING=1:
  - Stimulus: cbp=6'b000000, x=3, y=2; blk_done 3 cycles after each block_start.
  - Response: exactly 6 block_start pulses with s1_block 0,1,2,3,4,5; s1_coded all 1; s1_mb_x=3, s1_mb_y=2; mb_ready=1 one cycle after the 6th pulse.
- Non-intra macroblock:
  - Stimulus: cbp=6'b101001, intra=0.
  - Response: s1_coded sequence 1,0,1,0,0,1.
- MAX_OUTSTANDING=2, credit throttle:
  - Stimulus: blk_done withheld until cycle 10, then a blk_done in the same cycle as an issue.
  - Response: block_start on consecutive cycles for blocks 0 and 1; stall until blk_done; outstanding stays 2 across the simultaneous done+issue.
- Picture end:
  - Stimulus: pic_end during RUN of the last macroblock, with 2 blocks outstanding after the 6th issue.
  - Response: mb_ready=0 while in DRAIN; pic_done for one cycle, 2 cycles after the final blk_done; s1_enable=0 afterwards.
- Error and mid-operation reset:
  - Stimulus: blk_done while idle; separately, reset_n asserted after block 2 of a macroblock.
  - Response: err=1 and stays set. After reset, err=0, and the next macroblock issues again from block 0.

Source files
------------

// File: rtl/m2vblksched.sv
// rtl/m2vblksched.sv - MPEG2 block scheduler: expands a macroblock into six
// credit-throttled block issues and drains outstanding blocks at picture end.
module m2vblksched #(
  parameter int MBX_WIDTH       = 6,
  parameter int MBY_WIDTH       = 5,
  parameter int MAX_OUTSTANDING = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mb_valid_i,
  output logic                 mb_ready_o,
  input  logic [5:0]           mb_cbp_i,
  input  logic                 mb_intra_i,
  input  logic [MBX_WIDTH-1:0] mb_x_i,
  input  logic [MBY_WIDTH-1:0] mb_y_i,
  input  logic                 pic_end_i,
  input  logic                 blk_done_i,
  output logic                 block_start_o,
  output logic [2:0]           s1_block_o,
  output logic                 s1_coded_o,
  output logic                 s1_mb_intra_o,
  output logic [MBX_WIDTH-1:0] s1_mb_x_o,
  output logic [MBY_WIDTH-1:0] s1_mb_y_o,
  output logic                 s1_enable_o,
  output logic                 pic_done_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] MAX_OUT = 2'(MAX_OUTSTANDING);

  state_t                 state_q;
  logic [5:0]             cbp_q;
  logic                   intra_q;
  logic [MBX_WIDTH-1:0]   x_q;
  logic [MBY_WIDTH-1:0]   y_q;
  logic [2:0]             blk_cnt_q;
  logic [1:0]             out_q, out_d;
  logic                   err_q, err_d;
  logic                   pic_pend_q;
  logic                   block_start_q;
  logic [2:0]             s1_block_q;
  logic                   s1_coded_q;
  logic                   s1_mb_intra_q;
  logic [MBX_WIDTH-1:0]   s1_mb_x_q;
  logic [MBY_WIDTH-1:0]   s1_mb_y_q;
  logic                   s1_enable_q;
  logic                   pic_done_q;
  logic                   issue;

  // Credit check and counter update both use the pre-update outstanding count.
  always_comb begin
    issue = (state_q == RUN) && (out_q < MAX_OUT);
    out_d = out_q;
    err_d = err_q;
    if (issue && !blk_done_i) begin
      out_d = out_q + 2'd1;
    end else if (!issue && blk_done_i) begin
      if (out_q == 2'd0) begin
        err_d = 1'b1;
      end else begin
        out_d = out_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cbp_q         <= '0;
      intra_q       <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      blk_cnt_q     <= '0;
      out_q         <= '0;
      err_q         <= 1'b0;
      pic_pend_q    <= 1'b0;
      block_start_q <= 1'b0;
      s1_block_q    <= '0;
      s1_coded_q    <= 1'b0;
      s1_mb_intra_q <= 1'b0;
      s1_mb_x_q     <= '0;
      s1_mb_y_q     <= '0;
      s1_enable_q   <= 1'b0;
      pic_done_q    <= 1'b0;
    end else begin
      out_q         <= out_d;
      err_q         <= err_d;
      block_start_q <= 1'b0;
      pic_done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mb_valid_i) begin
            cbp_q     <= mb_cbp_i;
            intra_q   <= mb_intra_i;
            x_q       <= mb_x_i;
            y_q       <= mb_y_i;
            blk_cnt_q <= '0;
            state_q   <= RUN;
            if (pic_end_i) begin
              pic_pend_q <= 1'b1;
            end
          end else if (pic_end_i || pic_pend_q) begin
            pic_pend_q <= 1'b0;
            state_q    <= DRAIN;
          end
        end
        RUN: begin
          if (pic_end_i) begin
            pic_pend_q <= 1'b1;
          end
          if (issue) begin
            block_start_q <= 1'b1;
            s1_block_q    <= blk_cnt_q;
            // cbp bit 5 describes block 0, so index from the top.
            s1_coded_q    <= intra_q | cbp_q[3'd5 - blk_cnt_q];
            s1_mb_intra_q <= intra_q;
            s1_mb_x_q     <= x_q;
            s1_mb_y_q     <= y_q;
            s1_enable_q   <= 1'b1;
            blk_cnt_q     <= blk_cnt_q + 3'd1;
            if (blk_cnt_q == 3'd5) begin
              state_q <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (pic_end_i) begin
            pic_pend_q <= 1'b1;
          end
          if (out_q == 2'd0) begin
            pic_done_q  <= 1'b1;
            s1_enable_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mb_ready_o    = (state_q == IDLE);
  assign block_start_o = block_start_q;
  assign s1_block_o    = s1_block_q;
  assign s1_coded_o    = s1_coded_q;
  assign s1_mb_intra_o = s1_mb_intra_q;
  assign s1_mb_x_o     = s1_mb_x_q;
  assign s1_mb_y_o     = s1_mb_y_q;
  assign s1_enable_o   = s1_enable_q;
  assign pic_done_o    = pic_done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_m2vblksched.sv
// tb/tb_m2vblksched.sv - directed bench for m2vblksched with one-credit and
// two-credit instances driven from the same clock and reset.
module tb_m2vblksched;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] mb_cbp = '0;
  logic       mb_intra = 1'b0;
  logic [5:0] mb_x = '0;
  logic [4:0] mb_y = '0;

  logic       mb_valid1 = 1'b0, pic_end1 = 1'b0, blk_done1 = 1'b0;
  logic       mb_ready1, block_start1, s1_coded1, s1_mb_intra1, s1_enable1, pic_done1, err1;
  logic [2:0] s1_block1;
  logic [5:0] s1_mb_x1;
  logic [4:0] s1_mb_y1;

  logic       mb_valid2 = 1'b0, pic_end2 = 1'b0, blk_done2 = 1'b0;
  logic       mb_ready2, block_start2, s1_coded2, s1_mb_intra2, s1_enable2, pic_done2, err2;
  logic [2:0] s1_block2;
  logic [5:0] s1_mb_x2;
  logic [4:0] s1_mb_y2;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  m2vblksched #(.MBX_WIDTH(6), .MBY_WIDTH(5), .MAX_OUTSTANDING(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .mb_valid_i(mb_valid1), .mb_ready_o(mb_ready1),
    .mb_cbp_i(mb_cbp), .mb_intra_i(mb_intra), .mb_x_i(mb_x), .mb_y_i(mb_y),
    .pic_end_i(pic_end1), .blk_done_i(blk_done1),
    .block_start_o(block_start1), .s1_block_o(s1_block1), .s1_coded_o(s1_coded1),
    .s1_mb_intra_o(s1_mb_intra1), .s1_mb_x_o(s1_mb_x1), .s1_mb_y_o(s1_mb_y1),
    .s1_enable_o(s1_enable1), .pic_done_o(pic_done1), .err_o(err1)
  );

  m2vblksched #(.MBX_WIDTH(6), .MBY_WIDTH(5), .MAX_OUTSTANDING(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n),
    .mb_valid_i(mb_valid2), .mb_ready_o(mb_ready2),
    .mb_cbp_i(mb_cbp), .mb_intra_i(mb_intra), .mb_x_i(mb_x), .mb_y_i(mb_y),
    .pic_end_i(pic_end2), .blk_done_i(blk_done2),
    .block_start_o(block_start2), .s1_block_o(s1_block2), .s1_coded_o(s1_coded2),
    .s1_mb_intra_o(s1_mb_intra2), .s1_mb_x_o(s1_mb_x2), .s1_mb_y_o(s1_mb_y2),
    .s1_enable_o(s1_enable2), .pic_done_o(pic_done2), .err_o(err2)
  );

  // Drives one macroblock into the one-credit instance, retiring each block
  // three cycles after its block_start, and records what was issued.
  task automatic run_mb1(input logic [5:0] cbp, input logic intra, input logic [5:0] x,
                         input logic [4:0] y, output int n, output logic [17:0] blks,
                         output logic [5:0] coded, output logic attr_ok, output int first_cyc,
                         output logic gap_ok, output logic ready_after);
    int   cyc, wait_cnt, last_pulse;
    logic chk_ready;
    n = 0; blks = '0; coded = '0; attr_ok = 1'b1; first_cyc = -1; gap_ok = 1'b1;
    ready_after = 1'b0; wait_cnt = -1; last_pulse = -1; chk_ready = 1'b0; cyc = 0;
    mb_cbp = cbp; mb_intra = intra; mb_x = x; mb_y = y; mb_valid1 = 1'b1;
    @(negedge clk);
    mb_valid1 = 1'b0;
    while ((n < 6 || wait_cnt >= 0 || chk_ready) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      blk_done1 = 1'b0;
      if (chk_ready) begin
        ready_after = mb_ready1;
        chk_ready = 1'b0;
      end
      if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          blk_done1 = 1'b1;
          wait_cnt = -1;
        end
      end
      if (block_start1) begin
        if (n < 6) begin
          blks[3*n +: 3] = s1_block1;
          coded[5-n] = s1_coded1;
        end
        if (s1_mb_x1 !== x || s1_mb_y1 !== y || s1_mb_intra1 !== intra || s1_enable1 !== 1'b1)
          attr_ok = 1'b0;
        if (n == 0) first_cyc = cyc;
        else if (cyc - last_pulse != 5) gap_ok = 1'b0;
        last_pulse = cyc;
        n++;
        wait_cnt = 3;
        if (n == 6) chk_ready = 1'b1;
      end
    end
    @(negedge clk);
    blk_done1 = 1'b0;
  endtask

  task automatic test_reset();
    int pulses;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mb_ready1 !== 1'b1 || mb_ready2 !== 1'b1) begin
      n_fail++; $display("FAIL reset_mb_ready: got %b/%b expected 1/1", mb_ready1, mb_ready2);
    end
    n_checks++;
    if ({block_start1, s1_block1, s1_coded1, s1_mb_intra1, s1_mb_x1, s1_mb_y1, s1_enable1,
         pic_done1, err1} !== 20'd0) begin
      n_fail++; $display("FAIL reset_outputs_dut1: got nonzero outputs expected 0");
    end
    n_checks++;
    if ({block_start2, s1_block2, s1_coded2, s1_mb_intra2, s1_mb_x2, s1_mb_y2, s1_enable2,
         pic_done2, err2} !== 20'd0) begin
      n_fail++; $display("FAIL reset_outputs_dut2: got nonzero outputs expected 0");
    end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (block_start1 || block_start2) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL reset_idle_pulses: got %0d expected 0", pulses);
    end
  endtask

  task automatic test_intra();
    int n, first_cyc;
    logic [17:0] blks;
    logic [5:0] coded;
    logic attr_ok, gap_ok, ready_after;
    run_mb1(6'b000000, 1'b1, 6'd3, 5'd2, n, blks, coded, attr_ok, first_cyc, gap_ok, ready_after);
    n_checks++;
    if (n != 6) begin n_fail++; $display("FAIL intra_pulse_count: got %0d expected 6", n); end
    n_checks++;
    if (blks !== 18'o543210) begin n_fail++; $display("FAIL intra_block_seq: got %o expected 543210", blks); end
    n_checks++;
    if (coded !== 6'b111111) begin n_fail++; $display("FAIL intra_coded: got %b expected 111111", coded); end
    n_checks++;
    if (attr_ok !== 1'b1) begin n_fail++; $display("FAIL intra_attrs: got %b expected 1", attr_ok); end
    n_checks++;
    if (first_cyc != 1) begin n_fail++; $display("FAIL intra_first_latency: got %0d expected 1", first_cyc); end
    n_checks++;
    if (gap_ok !== 1'b1) begin n_fail++; $display("FAIL intra_done_to_start_gap: got %b expected 1", gap_ok); end
    n_checks++;
    if (ready_after !== 1'b1) begin n_fail++; $display("FAIL intra_ready_after_6th: got %b expected 1", ready_after); end
    n_checks++;
    if (err1 !== 1'b0) begin n_fail++; $display("FAIL intra_err: got %b expected 0", err1); end
  endtask

  task automatic test_non_intra();
    int n, first_cyc;
    logic [17:0] blks;
    logic [5:0] coded;
    logic attr_ok, gap_ok, ready_after;
    run_mb1(6'b101001, 1'b0, 6'd45, 5'd17, n, blks, coded, attr_ok, first_cyc, gap_ok, ready_after);
    n_checks++;
    if (n != 6) begin n_fail++; $display("FAIL nonintra_pulse_count: got %0d expected 6", n); end
    // coded is packed block 0 first (MSB): sequence 1,0,1,0,0,1
    n_checks++;
    if (coded !== 6'b101001) begin n_fail++; $display("FAIL nonintra_coded: got %b expected 101001", coded); end
    n_checks++;
    if (attr_ok !== 1'b1) begin n_fail++; $display("FAIL nonintra_attrs: got %b expected 1", attr_ok); end
  endtask

  task automatic test_credit_throttle();
    int exp_cyc [6] = '{1, 2, 12, 13, 21, 22};
    int pcyc [6];
    logic [2:0] pblk [6];
    int n;
    n = 0;
    for (int i = 0; i < 6; i++) begin pcyc[i] = -1; pblk[i] = '0; end
    mb_cbp = 6'b110011; mb_intra = 1'b0; mb_x = 6'd20; mb_y = 5'd4; mb_valid2 = 1'b1;
    @(negedge clk);
    mb_valid2 = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (block_start2) begin
        if (n < 6) begin pcyc[n] = k; pblk[n] = s1_block2; end
        n++;
      end
      blk_done2 = (k == 10 || k == 11 || k == 19 || k == 20 || k == 21 || k == 22);
    end
    n_checks++;
    if (n != 6) begin n_fail++; $display("FAIL credit_pulse_count: got %0d expected 6", n); end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (pcyc[i] != exp_cyc[i] || pblk[i] !== 3'(i)) begin
        n_fail++;
        $display("FAIL credit_issue_%0d: got cycle %0d block %0d expected cycle %0d block %0d",
                 i, pcyc[i], pblk[i], exp_cyc[i], i);
      end
    end
    n_checks++;
    if (mb_ready2 !== 1'b1 || err2 !== 1'b0) begin
      n_fail++; $display("FAIL credit_end_state: got ready %b err %b expected 1 0", mb_ready2, err2);
    end
  endtask

  task automatic test_pic_end();
    int n, last_pulse, pd_cnt, pd_cyc;
    logic both, ready_in_drain, en_before, en_after;
    n = 0; last_pulse = -1; pd_cnt = 0; pd_cyc = -1;
    both = 1'b0; ready_in_drain = 1'b0; en_before = 1'b0; en_after = 1'b1;
    mb_cbp = 6'b000111; mb_intra = 1'b0; mb_x = 6'd30; mb_y = 5'd31; mb_valid2 = 1'b1;
    @(negedge clk);
    mb_valid2 = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (block_start2) begin n++; last_pulse = k; end
      if (block_start2 && pic_done2) both = 1'b1;
      if (pic_done2) begin pd_cnt++; pd_cyc = k; end
      if (k >= 10 && k <= 17 && mb_ready2) ready_in_drain = 1'b1;
      if (k == 17) en_before = s1_enable2;
      if (k == 19) en_after = s1_enable2;
      blk_done2 = (k == 4 || k == 5 || k == 6 || k == 7 || k == 15 || k == 16);
      pic_end2 = (k == 3);
    end
    n_checks++;
    if (n != 6 || last_pulse != 9) begin
      n_fail++; $display("FAIL picend_issues: got %0d pulses last %0d expected 6 last 9", n, last_pulse);
    end
    n_checks++;
    if (ready_in_drain !== 1'b0) begin n_fail++; $display("FAIL picend_ready_in_drain: got 1 expected 0"); end
    n_checks++;
    if (pd_cnt != 1 || pd_cyc != 18) begin
      n_fail++; $display("FAIL picend_pic_done: got %0d pulses at %0d expected 1 at 18", pd_cnt, pd_cyc);
    end
    n_checks++;
    if (en_before !== 1'b1 || en_after !== 1'b0) begin
      n_fail++; $display("FAIL picend_s1_enable: got %b->%b expected 1->0", en_before, en_after);
    end
    n_checks++;
    if (both !== 1'b0) begin n_fail++; $display("FAIL picend_overlap: got 1 expected 0"); end
    n_checks++;
    if (mb_ready2 !== 1'b1 || err2 !== 1'b0) begin
      n_fail++; $display("FAIL picend_end_state: got ready %b err %b expected 1 0", mb_ready2, err2);
    end
  endtask

  task automatic test_error_and_reset();
    int cyc, wait_cnt, n, first_cyc;
    logic found, attr_ok, gap_ok, ready_after;
    logic [17:0] blks;
    logic [5:0] coded;
    blk_done1 = 1'b1;
    @(negedge clk);
    blk_done1 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err1 !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", err1); end
    repeat (5) @(negedge clk);
    n_checks++;
    if (err1 !== 1'b1 || mb_ready1 !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: got err %b ready %b expected 1 1", err1, mb_ready1);
    end
    mb_cbp = 6'b111111; mb_intra = 1'b0; mb_x = 6'd12; mb_y = 5'd8; mb_valid1 = 1'b1;
    @(negedge clk);
    mb_valid1 = 1'b0;
    found = 1'b0; cyc = 0; wait_cnt = -1;
    while (!found && cyc < 50) begin
      @(negedge clk);
      cyc++;
      blk_done1 = 1'b0;
      if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin blk_done1 = 1'b1; wait_cnt = -1; end
      end
      if (block_start1) begin
        if (s1_block1 == 3'd2) found = 1'b1;
        else wait_cnt = 2;
      end
    end
    n_checks++;
    if (found !== 1'b1) begin n_fail++; $display("FAIL midreset_reach_block2: got 0 expected 1"); end
    blk_done1 = 1'b0;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (err1 !== 1'b0 || block_start1 !== 1'b0 || mb_ready1 !== 1'b1 || s1_enable1 !== 1'b0 ||
        s1_block1 !== 3'd0) begin
      n_fail++;
      $display("FAIL midreset_clear: got err %b start %b ready %b en %b blk %0d expected 0 0 1 0 0",
               err1, block_start1, mb_ready1, s1_enable1, s1_block1);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_mb1(6'b010000, 1'b0, 6'd7, 5'd9, n, blks, coded, attr_ok, first_cyc, gap_ok, ready_after);
    n_checks++;
    if (n != 6 || blks !== 18'o543210) begin
      n_fail++; $display("FAIL midreset_reissue: got %0d pulses seq %o expected 6 seq 543210", n, blks);
    end
    n_checks++;
    if (coded !== 6'b010000 || first_cyc != 1 || err1 !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_after: got coded %b first %0d err %b expected 010000 1 0",
               coded, first_cyc, err1);
    end
  endtask

  initial begin
    test_reset();
    test_intra();
    test_non_intra();
    test_credit_throttle();
    test_pic_end();
    test_error_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
